// File: rtl/iagc_pkg.sv
// Shared IAGC status encodings, bus width and UART command bytes.
// Used by the sequencer, dump_unit, sampler and UART mux.
package iagc_pkg;

    localparam int IAGC_STATUS_SIZE = 4;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_INIT      = 4'd1,
        ST_IDLE      = 4'd2,
        ST_SAMPLE    = 4'd3,
        ST_CMD_PARSE = 4'd4,
        ST_CMD_READ  = 4'd5,
        ST_CMD_ERROR = 4'd6,
        ST_DUMP_MEM  = 4'd7
    } iagc_status_e;

    localparam logic [7:0] CMD_SAMPLE = 8'h53;
    localparam logic [7:0] CMD_DUMP   = 8'h44;
    localparam logic [7:0] CMD_RESET  = 8'h52;

endpackage

// File: rtl/iagc_cycle_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
// Latency: load takes effect on the next edge; no backpressure.
module iagc_cycle_timer
    import iagc_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/iagc_sequencer.sv
// Command sequencer: decodes UART command bytes and owns the IAGC status bus.
// Latency: command byte to target state in 3 edges; bytes outside IDLE are dropped (no backpressure).
module iagc_sequencer #(
    parameter int                   DATA_SIZE        = 8,
    parameter int                   IAGC_STATUS_SIZE = iagc_pkg::IAGC_STATUS_SIZE,
    parameter int                   INIT_CYCLES      = 16,
    parameter int                   ERROR_CYCLES     = 4,
    parameter int                   SAMPLE_TIMEOUT   = 1000000,
    parameter logic [DATA_SIZE-1:0] CMD_SAMPLE       = DATA_SIZE'(iagc_pkg::CMD_SAMPLE),
    parameter logic [DATA_SIZE-1:0] CMD_DUMP         = DATA_SIZE'(iagc_pkg::CMD_DUMP),
    parameter logic [DATA_SIZE-1:0] CMD_RESET        = DATA_SIZE'(iagc_pkg::CMD_RESET)
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [DATA_SIZE-1:0]        i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_sample_done,
    input  logic                        i_dump_end,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic [DATA_SIZE-1:0]        o_cmd,
    output logic                        o_sample_start,
    output logic                        o_error,
    output logic                        o_rx_drop
);
    import iagc_pkg::*;

    localparam int TMR_MAX0  = (INIT_CYCLES > ERROR_CYCLES) ? INIT_CYCLES : ERROR_CYCLES;
    localparam int TMR_LIMIT = (SAMPLE_TIMEOUT > TMR_MAX0) ? SAMPLE_TIMEOUT : TMR_MAX0;
    localparam int TMR_W     = (TMR_LIMIT > 1) ? $clog2(TMR_LIMIT) : 1;

    iagc_status_e         state_q, state_d;
    logic [DATA_SIZE-1:0] cmd_q, cmd_d;
    logic                 start_q, start_d;
    logic                 drop_q, drop_d;
    logic                 tmr_load, tmr_done;
    logic [TMR_W-1:0]     tmr_val;
    logic                 rx_reset_cmd;

    iagc_cycle_timer #(.WIDTH(TMR_W)) u_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_RESET;
            cmd_q   <= '0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        drop_d       = 1'b0;
        rx_reset_cmd = i_rx_valid && (i_rx_data == CMD_RESET);
        case (state_q)
            ST_RESET: begin
                drop_d  = i_rx_valid;
                state_d = ST_INIT;
            end
            ST_INIT: begin
                drop_d = i_rx_valid;
                if (tmr_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_rx_valid) begin
                    cmd_d   = i_rx_data;
                    state_d = ST_CMD_READ;
                end
            end
            ST_CMD_READ: begin
                drop_d  = i_rx_valid;
                state_d = ST_CMD_PARSE;
            end
            ST_CMD_PARSE: begin
                drop_d = i_rx_valid;
                if (cmd_q == CMD_SAMPLE)     state_d = ST_SAMPLE;
                else if (cmd_q == CMD_DUMP)  state_d = ST_DUMP_MEM;
                else if (cmd_q == CMD_RESET) state_d = ST_RESET;
                else                         state_d = ST_CMD_ERROR;
            end
            // A soft-reset byte aborts the running operation instead of being dropped.
            ST_SAMPLE: begin
                if (rx_reset_cmd) begin
                    state_d = ST_RESET;
                end else begin
                    drop_d = i_rx_valid;
                    if (i_sample_done) state_d = ST_IDLE;
                    else if (tmr_done) state_d = ST_CMD_ERROR;
                end
            end
            ST_DUMP_MEM: begin
                if (rx_reset_cmd) begin
                    state_d = ST_RESET;
                end else begin
                    drop_d = i_rx_valid;
                    if (i_dump_end) state_d = ST_IDLE;
                end
            end
            ST_CMD_ERROR: begin
                drop_d = i_rx_valid;
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase

        start_d  = (state_d == ST_SAMPLE) && (state_q != ST_SAMPLE);
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_INIT:      tmr_val = TMR_W'(INIT_CYCLES - 1);
            ST_CMD_ERROR: tmr_val = TMR_W'(ERROR_CYCLES - 1);
            ST_SAMPLE:    tmr_val = TMR_W'(SAMPLE_TIMEOUT - 1);
            default:      tmr_val = '0;
        endcase
    end

    assign o_iagc_status  = IAGC_STATUS_SIZE'(state_q);
    assign o_cmd          = cmd_q;
    assign o_sample_start = start_q;
    assign o_error        = (state_q == ST_CMD_ERROR);
    assign o_rx_drop      = drop_q;

endmodule

// File: doc/iagc_sequencer.md
Name: iagc_sequencer

Overview:
- Top-level command sequencer for the IAGC capture engine.
- Decodes single-byte commands from the UART receiver and drives the shared 4-bit IAGC status bus consumed by dump_unit, the sampler and the UART mux.
- Owns the ordering of reset, init, sampling, memory dump and error recovery.
- Is the only writer of the status bus.

Parameters:
- DATA_SIZE, 8, width of received command byte
- IAGC_STATUS_SIZE, 4, width of status bus
- INIT_CYCLES, 16, cycles spent in INIT after reset
- ERROR_CYCLES, 4, cycles spent in CMD_ERROR
- SAMPLE_TIMEOUT, 1000000, max cycles in SAMPLE before abort
- CMD_SAMPLE, 8'h53, 'S': start sampling
- CMD_DUMP, 8'h44, 'D': dump memory
- CMD_RESET, 8'h52, 'R': soft reset

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_rx_data  in  DATA_SIZE  received byte, valid with i_rx_valid
- i_rx_valid  in  1  one-cycle strobe, new byte
- i_sample_done  in  1  sampler finished filling memory
- i_dump_end  in  1  dump_unit o_end
- o_iagc_status  out  IAGC_STATUS_SIZE  status bus
- o_cmd  out  DATA_SIZE  last latched command byte
- o_sample_start  out  1  one-cycle pulse on SAMPLE entry
- o_error  out  1  high while in CMD_ERROR
- o_rx_drop  out  1  one-cycle pulse when a byte is ignored

Behaviour:
- Synchronous, active-high reset:
  - While i_reset is high at a clock edge: status RESET (4'b0000), o_cmd=0, o_sample_start=0, o_rx_drop=0, counters=0.
- o_iagc_status is the registered state. Encodings: RESET 0, INIT 1, IDLE 2, SAMPLE 3, CMD_PARSE 4, CMD_READ 5, CMD_ERROR 6, DUMP_MEM 7.
- RESET -> INIT on the first edge with i_reset low.
- INIT: hold exactly INIT_CYCLES cycles -> IDLE.
- IDLE:
  - i_rx_valid=1 at edge N: latch i_rx_data into o_cmd; status CMD_READ after N.
  - Then CMD_PARSE after N+1.
  - Then the target state after N+2.
- CMD_PARSE decode:
  - CMD_SAMPLE -> SAMPLE, with o_sample_start=1 for the first SAMPLE cycle only.
  - CMD_DUMP -> DUMP_MEM.
  - CMD_RESET -> RESET for one cycle -> INIT.
  - Any other byte -> CMD_ERROR.
- SAMPLE:
  - i_sample_done=1 -> IDLE next edge.
  - Timeout counter reaches SAMPLE_TIMEOUT-1 without done -> CMD_ERROR.
  - If done and timeout coincide, done wins (IDLE).
- DUMP_MEM:
  - Leave to IDLE on the first edge i_dump_end=1.
  - This guarantees dump_unit does not restart from its INIT state.
  - DUMP_MEM has no timeout.
- CMD_ERROR: hold exactly ERROR_CYCLES cycles with o_error=1 -> IDLE.
- i_rx_valid in any state other than IDLE:
  - Byte discarded; o_cmd unchanged; o_rx_drop=1 for one cycle.
  - Exception: CMD_RESET received in SAMPLE or DUMP_MEM is honoured. It aborts the operation: RESET for one cycle, then INIT. o_rx_drop=0.
- i_reset mid-operation overrides everything on that edge; all counters clear.
- Counters sized with $clog2 of their limit. Timeout counter saturates and never wraps.
- i_sample_done / i_dump_end are ignored outside their own states.

Decomposition:
- Shared package iagc_pkg:
  - status encodings (also used by dump_unit, sampler, uart mux)
  - IAGC_STATUS_SIZE
  - command byte constants
- One sub-module, iagc_cycle_timer: loadable down-counter with a done flag.
  - Reused for the INIT, CMD_ERROR and SAMPLE timeout waits.
  - The sequencer loads it on each state entry.

Test Plan:
- Reset held 3 cycles then released:
  - status=0 through release, then 1 for 16 cycles, then 2.
  - o_cmd=0x00.
- In IDLE, rx 0x53 at cycle N:
  - status 5 @N+1, 4 @N+2, 3 @N+3 with o_sample_start=1 only @N+3.
  - i_sample_done @N+10 -> status 2 @N+11.
- In IDLE, rx 0x44:
  - status 7 after 3 cycles.
  - Pulse i_dump_end for 4 cycles -> status 2 one cycle after the first end cycle; stays 2.
- In IDLE, rx 0x41:
  - status 6 with o_error=1 for exactly 4 cycles, then 2.
  - o_cmd=0x41.
- In SAMPLE:
  - rx 0x44 -> o_rx_drop pulse, state unchanged.
  - rx 0x52 -> status 0 for one cycle, 1 for 16 cycles, then 2.
- SAMPLE_TIMEOUT=20, no done -> CMD_ERROR after 20 SAMPLE cycles.
- i_reset asserted mid-DUMP_MEM -> status 0 next edge, all counters clear.
